// File: rtl/ddr3_request_bridge.sv
// rtl/ddr3_request_bridge.sv - single-word client request to Avalon-MM f2h_sdram bridge
// Each client request becomes one burst-1 transfer followed by a one-cycle completion pulse.
module ddr3_request_bridge #(
  parameter int AVM_ADDR_W     = 27,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           sdram_address,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [127:0]          write_data_input,
  output logic [127:0]          read_data,
  output logic                  write_complete,
  output logic                  read_complete,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [127:0]          avm_writedata,
  output logic [15:0]           avm_byteenable,
  output logic [0:0]            avm_burstcount,
  input  logic                  avm_waitrequest,
  input  logic [127:0]          avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE_REQ = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    DONE_WR   = 3'd4,
    DONE_RD   = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic          capture;
  logic          time_hit;
  logic          write_n;
  logic          read_n;
  logic          write_complete_n;
  logic          read_complete_n;
  logic          busy_n;

  assign avm_byteenable = 16'hFFFF;
  assign avm_burstcount = 1'b1;

  // Low nibble is the byte offset inside a 128-bit word; high bits beyond the port are dropped.
  logic unused_lo;
  assign unused_lo = ^sdram_address[3:0];
  generate
    if (AVM_ADDR_W + 4 < 32) begin : g_drop_hi
      logic unused_hi;
      assign unused_hi = ^sdram_address[31:AVM_ADDR_W+4];
    end
  endgenerate

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    time_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en)      next_state = WRITE_REQ;
        else if (rd_en) next_state = READ_REQ;
      end
      WRITE_REQ: if (!avm_waitrequest) next_state = DONE_WR;
      READ_REQ:  if (!avm_waitrequest) next_state = READ_WAIT;
      READ_WAIT: begin
        if (avm_readdatavalid) begin
          capture    = 1'b1;
          next_state = DONE_RD;
        end else if (TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES)) begin
          time_hit   = 1'b1;
          next_state = DONE_RD;
        end
      end
      DONE_WR:   next_state = IDLE;
      DONE_RD:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    write_n          = (next_state == WRITE_REQ);
    read_n           = (next_state == READ_REQ);
    write_complete_n = (next_state == DONE_WR);
    read_complete_n  = (next_state == DONE_RD);
    busy_n           = (next_state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      read_data      <= '0;
      write_complete <= 1'b0;
      read_complete  <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      state          <= next_state;
      avm_write      <= write_n;
      avm_read       <= read_n;
      write_complete <= write_complete_n;
      read_complete  <= read_complete_n;
      busy           <= busy_n;
      if (state == IDLE && (wr_en || rd_en))
        avm_address <= sdram_address[AVM_ADDR_W+3:4];
      if (state == IDLE && wr_en)
        avm_writedata <= write_data_input;
      if (capture)
        read_data <= avm_readdata;
      if (time_hit)
        timeout_err <= 1'b1;
      // Timer restarts on every entry to READ_WAIT and saturates rather than wrapping.
      if (state != READ_WAIT)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_request_bridge.sv
// tb/tb_ddr3_request_bridge.sv - directed self-checking bench for ddr3_request_bridge
// Each task drives a cycle-indexed scenario and checks registered outputs 1ns after the edge.
module tb_ddr3_request_bridge;

  logic         clock;
  logic         reset;
  logic [31:0]  sdram_address;
  logic         rd_en;
  logic         wr_en;
  logic [127:0] write_data_input;
  logic [127:0] read_data;
  logic         write_complete;
  logic         read_complete;
  logic         busy;
  logic         timeout_err;
  logic [26:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [0:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [127:0] avm_readdata;
  logic         avm_readdatavalid;

  int checks;
  int errors;

  ddr3_request_bridge #(.AVM_ADDR_W(27), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .sdram_address(sdram_address), .rd_en(rd_en), .wr_en(wr_en),
    .write_data_input(write_data_input), .read_data(read_data), .write_complete(write_complete),
    .read_complete(read_complete), .busy(busy), .timeout_err(timeout_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; avm_waitrequest = 0; avm_readdatavalid = 0;
    avm_readdata = 128'h0; write_data_input = 128'h0; sdram_address = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    checks++;
    if ({read_data, write_complete, read_complete, busy, timeout_err, avm_read, avm_write} !== 134'h0) begin
      errors++; $display("FAIL reset_outputs got rd=%0h wc=%0b rc=%0b busy=%0b to=%0b r=%0b w=%0b want all 0",
                         read_data, write_complete, read_complete, busy, timeout_err, avm_read, avm_write);
    end
    checks++;
    if (avm_address !== 27'h0 || avm_writedata !== 128'h0) begin
      errors++; $display("FAIL reset_avm got addr=%0h wd=%0h want 0 0", avm_address, avm_writedata);
    end
    checks++;
    if (avm_byteenable !== 16'hFFFF || avm_burstcount !== 1'b1) begin
      errors++; $display("FAIL reset_consts got be=%0h bc=%0h want ffff 1", avm_byteenable, avm_burstcount);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_write();
    int nw = 0; int nwc = 0;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin wr_en = 1; sdram_address = 32'h04000000; write_data_input = 128'hAB; end
      if (avm_write) nw++;
      if (write_complete) nwc++;
      if (c == 1) begin
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 27'h0400000 || avm_writedata !== 128'hAB || busy !== 1'b1) begin
          errors++; $display("FAIL write_c1 got w=%0b addr=%0h wd=%0h busy=%0b want 1 400000 ab 1",
                             avm_write, avm_address, avm_writedata, busy);
        end
      end
      if (c == 2) begin
        checks++;
        if (write_complete !== 1'b1 || avm_write !== 1'b0) begin
          errors++; $display("FAIL write_c2 got wc=%0b w=%0b want 1 0", write_complete, avm_write);
        end
      end
      if (c == 3) begin
        checks++;
        if (busy !== 1'b0 || write_complete !== 1'b0) begin
          errors++; $display("FAIL write_c3 got busy=%0b wc=%0b want 0 0", busy, write_complete);
        end
      end
      tick();
    end
    checks++;
    if (nw != 1 || nwc != 1) begin
      errors++; $display("FAIL write_counts got w=%0d wc=%0d want 1 1", nw, nwc);
    end
  endtask

  task automatic test_read_wait();
    int nr = 0; int nrc = 0; int bad_addr = 0;
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
      if (c == 0) begin rd_en = 1; sdram_address = 32'h04000000; end
      avm_waitrequest = (c >= 1 && c <= 3);
      avm_readdatavalid = (c == 9);
      avm_readdata = (c == 9) ? 128'hAB : 128'hDEAD;
      if (avm_read) begin
        nr++;
        if (avm_address !== 27'h0400000) bad_addr++;
      end
      if (read_complete) nrc++;
      if (c == 10) begin
        checks++;
        if (read_complete !== 1'b1 || read_data !== 128'hAB) begin
          errors++; $display("FAIL read_c10 got rc=%0b data=%0h want 1 ab", read_complete, read_data);
        end
      end
      tick();
    end
    checks++;
    if (nr != 4 || nrc != 1 || bad_addr != 0) begin
      errors++; $display("FAIL read_counts got read=%0d rc=%0d badaddr=%0d want 4 1 0", nr, nrc, bad_addr);
    end
  endtask

  task automatic test_both_enables();
    int nw = 0; int nr = 0; int nwc = 0; int nrc = 0;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) begin
        wr_en = 1; rd_en = 1; sdram_address = 32'hF0000010; write_data_input = 128'h55;
      end
      if (avm_write) nw++;
      if (avm_read) nr++;
      if (write_complete) nwc++;
      if (read_complete) nrc++;
      if (c == 1) begin
        checks++;
        if (avm_address !== 27'h7000001 || avm_writedata !== 128'h55) begin
          errors++; $display("FAIL both_addr got addr=%0h wd=%0h want 7000001 55", avm_address, avm_writedata);
        end
      end
      tick();
    end
    checks++;
    if (nw != 1 || nr != 0 || nwc != 1 || nrc != 0) begin
      errors++; $display("FAIL both_counts got w=%0d r=%0d wc=%0d rc=%0d want 1 0 1 0", nw, nr, nwc, nrc);
    end
  endtask

  task automatic test_timeout();
    int nrc = 0;
    for (int c = 0; c < 22; c++) begin
      idle_inputs();
      if (c == 0) begin rd_en = 1; sdram_address = 32'h00000100; end
      if (read_complete) nrc++;
      if (c == 18) begin
        checks++;
        if (read_complete !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL timeout_c18 got rc=%0b to=%0b busy=%0b want 0 0 1", read_complete, timeout_err, busy);
        end
      end
      if (c == 19) begin
        checks++;
        if (read_complete !== 1'b1 || timeout_err !== 1'b1 || read_data !== 128'hAB) begin
          errors++; $display("FAIL timeout_c19 got rc=%0b to=%0b data=%0h want 1 1 ab", read_complete, timeout_err, read_data);
        end
      end
      tick();
    end
    checks++;
    if (nrc != 1 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_counts got rc=%0d to=%0b want 1 1", nrc, timeout_err);
    end
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) begin rd_en = 1; sdram_address = 32'h00000200; end
      avm_readdatavalid = (c == 3);
      avm_readdata = (c == 3) ? 128'h1234 : 128'hBEEF;
      if (c == 4) begin
        checks++;
        if (read_complete !== 1'b1 || read_data !== 128'h1234 || timeout_err !== 1'b1) begin
          errors++; $display("FAIL after_timeout got rc=%0b data=%0h to=%0b want 1 1234 1", read_complete, read_data, timeout_err);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_ignore();
    int nr = 0; int nrc = 0;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c == 0 || c == 3) begin rd_en = 1; sdram_address = 32'h00000300; end
      avm_readdatavalid = (c == 5);
      avm_readdata = (c == 5) ? 128'h77 : 128'h99;
      if (avm_read) nr++;
      if (read_complete) nrc++;
      if (c == 6) begin
        checks++;
        if (read_complete !== 1'b1 || read_data !== 128'h77) begin
          errors++; $display("FAIL ignore_c6 got rc=%0b data=%0h want 1 77", read_complete, read_data);
        end
      end
      tick();
    end
    checks++;
    if (nr != 1 || nrc != 1) begin
      errors++; $display("FAIL ignore_counts got read=%0d rc=%0d want 1 1", nr, nrc);
    end
  endtask

  task automatic test_reset_mid_write();
    int nrc = 0;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c == 0) begin wr_en = 1; sdram_address = 32'h00000400; write_data_input = 128'h66; end
      avm_waitrequest = (c <= 2);
      reset = (c == 2);
      avm_readdatavalid = (c == 4);
      avm_readdata = (c == 4) ? 128'hFF : 128'h0;
      if (c >= 3 && read_complete) nrc++;
      if (c == 2) begin
        checks++;
        if (avm_write !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL rstmid_c2 got w=%0b busy=%0b want 1 1", avm_write, busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || read_data !== 128'h0) begin
          errors++; $display("FAIL rstmid_c3 got w=%0b busy=%0b to=%0b data=%0h want 0 0 0 0",
                             avm_write, busy, timeout_err, read_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (read_data !== 128'h0) begin
          errors++; $display("FAIL stray_valid got data=%0h want 0", read_data);
        end
      end
      tick();
    end
    checks++;
    if (nrc != 0) begin
      errors++; $display("FAIL stray_rc got rc=%0d want 0", nrc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1;
    idle_inputs();
    #1;
    test_reset();
    test_write();
    test_read_wait();
    test_both_enables();
    test_timeout();
    test_back_to_back_ignore();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
